// File: rtl/uart_fifo_top.sv
// FIFO-buffered UART subsystem for the strobe-decoded port bus: TX/RX bit engines,
// TX/RX FIFOs, a TX drain FSM, an RX capture FSM, status/count reads and a level interrupt.
module uart_fifo_top #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EIGHT,
  input  logic        PEN,
  input  logic        OHEL,
  input  logic [18:0] k,
  input  logic        RX,
  input  logic [15:0] READS,
  input  logic [15:0] WRITES,
  input  logic [7:0]  OUT_PORT,
  output logic        TX,
  output logic [7:0]  IN_PORT,
  output logic        INT
);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_LOAD = 2'd1;
  localparam logic [1:0] TX_BUSY = 2'd2;
  localparam logic [1:0] TX_DONE = 2'd3;
  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_CAP  = 2'd1;
  localparam logic [1:0] RX_WAIT = 2'd2;

  logic [1:0]    tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [3:0]    ier_q, ier_d;
  logic          txovr_q, txovr_d, rxovr_q, rxovr_d, int_q, int_d;
  logic          txrdy_s, rxrdy_s, perr_s, ferr_s, ovf_s;
  logic [7:0]    rx_data_s, tx_head_s, status_s;
  logic [9:0]    rx_head_s;
  logic [TXAW:0] tx_cnt_s;
  logic [RXAW:0] rx_cnt_s;
  logic          tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic          tx_push_s, tx_load_s, rx_push_s, rx_pop_s, stat_rd_s, txidle_s;
  logic          unused_s;

  assign tx_push_s = WRITES[0];
  assign tx_load_s = (tx_st_q == TX_LOAD);
  assign rx_push_s = (rx_st_q == RX_CAP);
  assign stat_rd_s = READS[1];
  assign rx_pop_s  = READS[0] & ~READS[1];
  assign txidle_s  = tx_empty_s & (tx_st_q == TX_IDLE) & txrdy_s;
  assign unused_s  = ^{READS[15:4], WRITES[15:2]};
  assign INT       = int_q;

  uart_tx_eng u_tx (
    .clk_i(clk), .rst_i(rst), .eight_i(EIGHT), .pen_i(PEN), .ohel_i(OHEL), .k_i(k),
    .load_i(tx_load_s), .data_i(tx_head_s), .tx_o(TX), .txrdy_o(txrdy_s)
  );

  uart_rx_eng u_rx (
    .clk_i(clk), .rst_i(rst), .rx_i(RX), .eight_i(EIGHT), .pen_i(PEN), .ohel_i(OHEL), .k_i(k),
    .clr_i(rx_push_s), .rxrdy_o(rxrdy_s), .perr_o(perr_s), .ferr_o(ferr_s), .ovf_o(ovf_s),
    .data_o(rx_data_s)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txf (
    .clk_i(clk), .rst_i(rst), .push_i(tx_push_s), .pop_i(tx_load_s), .wdata_i(OUT_PORT),
    .rdata_o(tx_head_s), .count_o(tx_cnt_s), .full_o(tx_full_s), .empty_o(tx_empty_s)
  );

  uart_fifo #(.WIDTH(10), .DEPTH(RX_DEPTH)) u_rxf (
    .clk_i(clk), .rst_i(rst), .push_i(rx_push_s), .pop_i(rx_pop_s),
    .wdata_i({ferr_s, perr_s, rx_data_s}), .rdata_o(rx_head_s), .count_o(rx_cnt_s),
    .full_o(rx_full_s), .empty_o(rx_empty_s)
  );

  // Status byte and priority read mux; head error flags are masked while the RX FIFO is empty
  always_comb begin
    status_s = {rx_full_s, txovr_q, txidle_s, rxovr_q, rx_head_s[9] & ~rx_empty_s,
                rx_head_s[8] & ~rx_empty_s, ~tx_full_s, ~rx_empty_s};
    if (READS[1]) begin
      IN_PORT = status_s;
    end else if (READS[0]) begin
      IN_PORT = rx_empty_s ? 8'h00 : rx_head_s[7:0];
    end else if (READS[2]) begin
      IN_PORT = 8'(rx_cnt_s);
    end else if (READS[3]) begin
      IN_PORT = 8'(tx_cnt_s);
    end else begin
      IN_PORT = 8'h00;
    end
  end

  // Sticky overflow flags: a set in the same cycle as a STATUS read wins over the clear
  always_comb begin
    ier_d   = WRITES[1] ? OUT_PORT[3:0] : ier_q;
    txovr_d = (tx_push_s & tx_full_s) | (txovr_q & ~stat_rd_s);
    rxovr_d = (rx_push_s & rx_full_s) | ovf_s | (rxovr_q & ~stat_rd_s);
    int_d   = |(ier_q & {txidle_s, rxovr_q | txovr_q, ~tx_full_s, ~rx_empty_s});
  end

  // TX drain FSM: one byte in flight, handshaking on the engine's TXRDY
  always_comb begin
    tx_st_d = tx_st_q;
    case (tx_st_q)
      TX_IDLE: tx_st_d = (!tx_empty_s && txrdy_s) ? TX_LOAD : TX_IDLE;
      TX_LOAD: tx_st_d = TX_BUSY;
      TX_BUSY: tx_st_d = txrdy_s ? TX_BUSY : TX_DONE;
      TX_DONE: tx_st_d = txrdy_s ? TX_IDLE : TX_DONE;
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // RX capture FSM: CAP pushes the completed frame and clears the engine's RXRDY
  always_comb begin
    rx_st_d = rx_st_q;
    case (rx_st_q)
      RX_IDLE: rx_st_d = rxrdy_s ? RX_CAP : RX_IDLE;
      RX_CAP:  rx_st_d = RX_WAIT;
      RX_WAIT: rx_st_d = rxrdy_s ? RX_WAIT : RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q <= TX_IDLE;
      rx_st_q <= RX_IDLE;
      ier_q   <= 4'd0;
      txovr_q <= 1'b0;
      rxovr_q <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      rx_st_q <= rx_st_d;
      ier_q   <= ier_d;
      txovr_q <= txovr_d;
      rxovr_q <= rxovr_d;
      int_q   <= int_d;
    end
  end
endmodule

// Circular FIFO; a push while full is dropped even if a pop happens on the same edge.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_q];
  assign count_o   = cnt_q;

  // Storage array, not reset
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok_s) wr_q <= wr_q + AW'(1'b1);
      if (pop_ok_s)  rd_q <= rd_q + AW'(1'b1);
      cnt_q <= cnt_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end
endmodule

// Serial transmitter: start, 7/8 data bits LSB first, optional parity, one stop; k clocks per bit.
module uart_tx_eng (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        eight_i,
  input  logic        pen_i,
  input  logic        ohel_i,
  input  logic [18:0] k_i,
  input  logic        load_i,
  input  logic [7:0]  data_i,
  output logic        tx_o,
  output logic        txrdy_o
);
  logic        busy_q, par_s;
  logic [10:0] sh_q, frame_s;
  logic [3:0]  bits_q, nbits_s;
  logic [18:0] tmr_q, k_m1_s;

  assign k_m1_s  = (k_i == 19'd0) ? 19'd0 : k_i - 19'd1;
  assign tx_o    = sh_q[0];
  assign txrdy_o = ~busy_q;

  // Frame assembly; OHEL=1 selects odd parity
  always_comb begin
    par_s = ^(eight_i ? data_i : {1'b0, data_i[6:0]}) ^ ohel_i;
    if (eight_i) begin
      frame_s = {1'b1, pen_i ? par_s : 1'b1, data_i, 1'b0};
      nbits_s = pen_i ? 4'd11 : 4'd10;
    end else begin
      frame_s = {2'b11, pen_i ? par_s : 1'b1, data_i[6:0], 1'b0};
      nbits_s = pen_i ? 4'd10 : 4'd9;
    end
  end

  // Bit shifter; the line rests high whenever the shifter is empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      sh_q   <= '1;
      bits_q <= 4'd0;
      tmr_q  <= 19'd0;
    end else if (!busy_q) begin
      if (load_i) begin
        busy_q <= 1'b1;
        sh_q   <= frame_s;
        bits_q <= nbits_s;
        tmr_q  <= k_m1_s;
      end
    end else if (tmr_q == 19'd0) begin
      tmr_q <= k_m1_s;
      if (bits_q == 4'd1) begin
        busy_q <= 1'b0;
        sh_q   <= '1;
      end else begin
        sh_q   <= {1'b1, sh_q[10:1]};
        bits_q <= bits_q - 4'd1;
      end
    end else begin
      tmr_q <= tmr_q - 19'd1;
    end
  end
endmodule

// Serial receiver: samples mid-bit after a synchronised start edge; CLR acknowledges RXRDY.
module uart_rx_eng (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        eight_i,
  input  logic        pen_i,
  input  logic        ohel_i,
  input  logic [18:0] k_i,
  input  logic        clr_i,
  output logic        rxrdy_o,
  output logic        perr_o,
  output logic        ferr_o,
  output logic        ovf_o,
  output logic [7:0]  data_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BITS  = 2'd2;

  logic        s1_q, s2_q, par_q, rxrdy_q, perr_q, ferr_q, ovf_q;
  logic [1:0]  st_q;
  logic [3:0]  idx_q, ndata_s;
  logic [7:0]  sh_q, data_q, dat_s;
  logic [18:0] tmr_q, k_m1_s, half_m1_s;

  assign k_m1_s    = (k_i == 19'd0) ? 19'd0 : k_i - 19'd1;
  assign half_m1_s = (k_i[18:1] == 18'd0) ? 19'd0 : {1'b0, k_i[18:1]} - 19'd1;
  assign ndata_s   = eight_i ? 4'd8 : 4'd7;
  assign dat_s     = eight_i ? sh_q : {1'b0, sh_q[6:0]};
  assign rxrdy_o   = rxrdy_q;
  assign perr_o    = perr_q;
  assign ferr_o    = ferr_q;
  assign ovf_o     = ovf_q;
  assign data_o    = data_q;

  // Synchroniser, bit sampler and result registers; a frame completing wins over CLR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b1; s2_q <= 1'b1; st_q <= S_IDLE; tmr_q <= 19'd0; idx_q <= 4'd0;
      sh_q <= 8'd0; par_q <= 1'b0; rxrdy_q <= 1'b0; perr_q <= 1'b0; ferr_q <= 1'b0;
      ovf_q <= 1'b0; data_q <= 8'd0;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
      if (clr_i) begin
        rxrdy_q <= 1'b0;
        ovf_q   <= 1'b0;
      end
      case (st_q)
        S_IDLE: begin
          if (!s2_q) begin
            st_q  <= S_START;
            tmr_q <= half_m1_s;
          end
        end
        S_START: begin
          if (tmr_q != 19'd0) begin
            tmr_q <= tmr_q - 19'd1;
          end else if (s2_q) begin
            st_q <= S_IDLE;
          end else begin
            st_q  <= S_BITS;
            tmr_q <= k_m1_s;
            idx_q <= 4'd0;
          end
        end
        S_BITS: begin
          if (tmr_q != 19'd0) begin
            tmr_q <= tmr_q - 19'd1;
          end else begin
            tmr_q <= k_m1_s;
            idx_q <= idx_q + 4'd1;
            if (idx_q < ndata_s) begin
              sh_q[idx_q[2:0]] <= s2_q;
            end else if (pen_i && idx_q == ndata_s) begin
              par_q <= s2_q;
            end else begin
              st_q    <= S_IDLE;
              data_q  <= dat_s;
              perr_q  <= pen_i & (^{dat_s, par_q, ohel_i});
              ferr_q  <= ~s2_q;
              rxrdy_q <= 1'b1;
              if (rxrdy_q && !clr_i) ovf_q <= 1'b1;
            end
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_fifo_top.md
Name: uart_fifo_top

Overview:
- Next-generation UART subsystem top.
- Wraps the existing UART_TX and UART_RX engines with parametrised TX and RX FIFOs, a TX drain state machine, an RX capture state machine, a readable status/count register set, and a maskable level interrupt.
- Sits on the processor's strobe-decoded port bus (READS/WRITES/OUT_PORT/IN_PORT) in place of the single-byte UART top.
- Lets software burst up to TX_DEPTH bytes and absorb RX_DEPTH bytes between services.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, 2..128.
- RX_DEPTH, 16, RX FIFO entries; power of 2, 2..128.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- EIGHT  in  1  8-bit data frame select, passed to both engines.
- PEN  in  1  parity enable, passed to both engines.
- OHEL  in  1  odd/even parity select, passed to both engines.
- k  in  19  bit-time count, passed to both engines.
- RX  in  1  serial input.
- READS  in  16  one-hot read strobes.
- WRITES  in  16  one-hot write strobes.
- OUT_PORT  in  8  write data.
- TX  out  1  serial output.
- IN_PORT  out  8  read data, combinational.
- INT  out  1  registered level interrupt.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset empties both FIFOs and zeroes pointers, counts, the sticky flags and IER. Both FSMs go to IDLE. INT=0, LOAD=0, CLR=0. TX idles high via the engine.
- Write map (all take effect on the clk edge):
  - WRITES[0]: push OUT_PORT into the TX FIFO. If the FIFO is full, the byte is dropped and sticky TXOVR is set.
  - WRITES[1]: IER <= OUT_PORT[3:0].
- Read map: IN_PORT is combinational, priority READS[1] > READS[0] > READS[2] > READS[3], else 8'h00.
  - READS[1]: STATUS.
  - READS[0]: RX head data byte. The pop occurs on the same edge. If the FIFO is empty, IN_PORT=0 and no state change.
  - READS[2]: RX count, zero-extended to 8 bits.
  - READS[3]: TX count, zero-extended to 8 bits.
- STATUS bits:
  - [0] RX not empty
  - [1] TX not full
  - [2] head PERR
  - [3] head FERR
  - [4] RXOVR (sticky)
  - [5] TXIDLE = TX FIFO empty AND drain FSM in IDLE AND engine TXRDY
  - [6] TXOVR (sticky)
  - [7] RX full
  - A STATUS read clears RXOVR and TXOVR on that edge. A set event in the same cycle wins.
- FIFOs: circular buffers with wrapping pointers and a count of width clog2(DEPTH)+1.
  - Simultaneous push and pop with count between 0 and DEPTH exclusive: count unchanged, both pointers advance.
  - Push and pop together when full: the pop succeeds and the push is dropped (TXOVR/RXOVR as applicable).
  - Pop together with push when empty: the pop is ignored and the push succeeds.
- RX entry width is 10 bits: {FERR, PERR, data[7:0]}.
- TX drain FSM:
  - IDLE: if the TX FIFO is not empty and TXRDY=1, go to LOAD.
  - LOAD: drive the head byte to the engine, assert LOAD for exactly 1 cycle, pop the FIFO, go to BUSY.
  - BUSY: wait for TXRDY=0, then go to DONE.
  - DONE: wait for TXRDY=1, then go to IDLE.
  - Latency: at most 1 byte is in flight. Back-to-back bytes start within 2 clk of TXRDY rising.
- RX capture FSM:
  - IDLE: on RXRDY=1, go to CAP.
  - CAP: push {FERR, PERR, DATA_OUT}, or set RXOVR if the FIFO is full. Assert engine CLR for 1 cycle. Go to WAIT.
  - WAIT: wait for RXRDY=0, then go to IDLE.
  - The engine OVF output is ORed into the RXOVR set term.
- INT is registered, updated every cycle, and is the OR of the enabled conditions:
  - (IER[0] & RX not empty)
  - (IER[1] & TX not full)
  - (IER[2] & (RXOVR | TXOVR))
  - (IER[3] & TXIDLE)
- Reset mid-frame: the engines are reset with rst. No partial byte is pushed into the RX FIFO. TX returns high the cycle after reset is released.

Test Plan:
- Reset, then read all: STATUS=8'h22, counts 0, INT=0, TX=1.
- Config k=4, EIGHT=1, PEN=0, loopback TX→RX; write 8'h55, 8'hA3, 8'h0F.
  - TX count reads 3, then drains.
  - LOAD pulses 3 times, 1 cycle each.
  - RX count reaches 3; pops return 55, A3, 0F in order; STATUS[0]=0 after.
- TX_DEPTH=16: 17 writes with TXRDY held low by engine busy → TX count=16, STATUS[6]=1; STATUS read clears it; the 17th byte is never transmitted.
- RX_DEPTH=4, no reads, 5 loopback frames → RX count=4, STATUS[7]=1, STATUS[4]=1; the first 4 bytes are intact.
- PEN=1, OHEL=1, inject a frame with wrong parity and then a good frame → head STATUS[2]=1; after the pop, STATUS[2]=0 for the second entry.
- IER=4'b0001, loopback 1 byte → INT rises 1 clk after the RX push; pop → INT=0 next clk.
  - IER=4'b1000 after the TX drain → INT=1.
- Simultaneous WRITES[0] and READS[0] with TX count=15 → TX count 16.
- Assert rst mid-byte → all counts 0, INT=0, and no extra RX entry after release.
